// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, 8-bit dividend by 4-bit divisor
// Define DIV_SIGNED_EN for two's complement operands and results; unsigned otherwise.
module seq_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic [7:0] quot,
   output logic [3:0] rem,
   output logic       busy,
   output logic       done,
   output logic       dz,
   output logic       ovf
);
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FIX, DONE} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] r_q, r_d;
   logic [7:0] quot_q, quot_d;
   logic [3:0] rem_q, rem_d;
   logic       dz_q, dz_d;
   logic       ovf_q, ovf_d;
`ifdef DIV_SIGNED_EN
   logic       sa_q, sa_d;
   logic       sb_q, sb_d;
`endif

   logic [4:0] r_shift;
   logic [3:0] r_sub;
   logic [7:0] fix_quot;
   logic [3:0] fix_rem;
   logic       fix_ovf;

   // a_q holds the raw dividend after IDLE, its magnitude after LOAD, and the quotient after SHIFT
   always_comb begin
      r_shift = {r_q, a_q[7]};
      r_sub   = r_shift[3:0] - b_q;
   end

   always_comb begin
`ifdef DIV_SIGNED_EN
      fix_quot = (sa_q ^ sb_q) ? (~a_q + 8'd1) : a_q;
      fix_rem  = sa_q ? (~r_q + 4'd1) : r_q;
      fix_ovf  = ~(sa_q ^ sb_q) & a_q[7];
`else
      fix_quot = a_q;
      fix_rem  = r_q;
      fix_ovf  = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
`ifdef DIV_SIGNED_EN
      sa_d    = sa_q;
      sb_d    = sb_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               a_d     = dividend;
               b_d     = divisor;
            end
         end
         LOAD: begin
            r_d   = 4'd0;
            cnt_d = 3'd0;
`ifdef DIV_SIGNED_EN
            sa_d  = a_q[7];
            sb_d  = b_q[3];
            a_d   = a_q[7] ? (~a_q + 8'd1) : a_q;
            b_d   = b_q[3] ? (~b_q + 4'd1) : b_q;
`endif
            if (b_q == 4'd0) begin
               state_d = DONE;
               quot_d  = 8'd0;
               rem_d   = 4'd0;
               dz_d    = 1'b1;
               ovf_d   = 1'b0;
            end else begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (r_shift >= {1'b0, b_q}) begin
               r_d = r_sub;
               a_d = {a_q[6:0], 1'b1};
            end else begin
               r_d = r_shift[3:0];
               a_d = {a_q[6:0], 1'b0};
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = DONE;
            quot_d  = fix_quot;
            rem_d   = fix_rem;
            dz_d    = 1'b0;
            ovf_d   = fix_ovf;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         a_q     <= 8'd0;
         b_q     <= 4'd0;
         r_q     <= 4'd0;
         quot_q  <= 8'd0;
         rem_q   <= 4'd0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
`endif
      end
   end

   assign quot = quot_q;
   assign rem  = rem_q;
   assign dz   = dz_q;
   assign ovf  = ovf_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request pulse, sampled on rising clk edge, from the button conditioning path.
REQ-004 SHALL have port dividend, input, 8 bits: numerator, same format as the multiplier product bus.
REQ-005 SHALL have port divisor, input, 4 bits: denominator, same format as the multiplier operand switches.
REQ-006 SHALL have port quot, output, 8 bits: registered quotient.
REQ-007 SHALL have port rem, output, 4 bits: registered remainder.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle result-valid strobe.
REQ-010 SHALL have port dz, output, 1 bit: divide-by-zero flag for the last result.
REQ-011 SHALL have port ovf, output, 1 bit: quotient overflow flag for the last result.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, SHIFT, FIX and DONE.
REQ-013 SHALL transition IDLE->LOAD when start=1 at a clk edge, latching dividend and divisor in that same edge.
REQ-014 SHALL transition LOAD->SHIFT, or LOAD->DONE with dz=1 when the latched divisor is 0.
REQ-015 SHALL stay in SHIFT for exactly 8 cycles, one restoring shift/subtract step per cycle on magnitudes, MSB first, using a 3-bit iteration counter that wraps 7->0 on exit.
REQ-016 SHALL transition SHIFT->FIX and apply the sign correction there, then FIX->DONE.
REQ-017 SHALL transition DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL latency: start sampled at edge k -> done=1 during cycle k+11 for normal operands, and during cycle k+2 for divide-by-zero.
REQ-019 SHALL drive busy=1 in states LOAD through DONE inclusive, and busy=0 only in IDLE.
REQ-020 SHALL ignore start whenever busy=1, including start asserted during DONE, with no queuing.
REQ-021 SHALL update quot, rem, dz and ovf only on entry to DONE, and hold them stable until the next DONE.
REQ-022 SHALL truncate the quotient toward zero in signed mode, with the remainder taking the sign of the dividend and |rem| < |divisor|.
REQ-023 SHALL on divide-by-zero drive quot=8'h00, rem=4'h0, dz=1 and ovf=0.
REQ-024 SHALL on the signed case dividend=-128, divisor=-1 drive quot=8'h80, rem=4'h0, ovf=1 and dz=0.
REQ-025 SHALL clear both dz and ovf in every result where they do not apply.

Reset
REQ-026 SHALL on rst=0, asynchronously, force state=IDLE, counter=0, quot=0, rem=0, busy=0, done=0, dz=0 and ovf=0.
REQ-027 SHALL on reset mid-operation abort the division with no done pulse, and accept the next start only after rst returns to 1.

Configuration
REQ-028 SHALL with macro DIV_SIGNED_EN defined treat dividend (-128..127), divisor (-8..7), quot and rem as two's complement, with FIX performing the negation and the overflow check.
REQ-029 SHALL with DIV_SIGNED_EN undefined treat all operands as unsigned (0..255, 1..15), make FIX a pass-through cycle, and tie ovf to 0; latency SHALL be identical in both builds.

Verification
REQ-030 SHALL cover: DIV_SIGNED_EN undefined, 200/7 -> quot=28, rem=4, done exactly 11 cycles after the start edge.
REQ-031 SHALL cover: DIV_SIGNED_EN defined, -100/7 -> quot=8'hF2 (-14), rem=4'hE (-2); and 100/-7 -> quot=8'hF2, rem=4'h2.
REQ-032 SHALL cover: divisor=0, dividend=55 -> dz=1, quot=0, rem=0, done 2 cycles after start, busy low on the following cycle.
REQ-033 SHALL cover: DIV_SIGNED_EN defined, -128/-1 -> ovf=1, quot=8'h80, rem=0; a following 127/1 -> ovf=0, quot=127.
REQ-034 SHALL cover: start pulses in cycles k+3 and k+11 -> ignored, with exactly one done and outputs matching the first operands; rst=0 in the 4th SHIFT cycle -> busy=0 and all outputs 0 immediately, no done.
